// File: rtl/mantissa_normalizer_if.sv
// Purpose: bundles the add/sub-result input bus and the normalized-result output bus of mantissa_normalizer.
// Latency: none, wires only.
// Backpressure: i_valid/o_ready on the input side, o_valid/i_ready on the output side.
// Ports: slave = normalizer side, master = upstream/downstream (or bench) side.
interface mantissa_normalizer_if #(
  parameter int SIZE_MANTISSA = 28,
  parameter int SIZE_EXP      = 8
);
  localparam int SC_W = $clog2(SIZE_MANTISSA) + 1;

  // upstream add/sub result
  logic                     i_valid;
  logic                     o_ready;
  logic                     i_overflow;
  logic                     i_sign;
  logic [SIZE_MANTISSA-1:0] i_mantissa;
  logic [SIZE_EXP-1:0]      i_exponent;

  // normalized result towards rounding
  logic                     o_valid;
  logic                     i_ready;
  logic                     o_sign;
  logic [SIZE_MANTISSA-1:0] o_mantissa;
  logic [SIZE_EXP-1:0]      o_exponent;
  logic                     o_zero;
  logic                     o_denorm;
  logic                     o_exp_overflow;
  logic [SC_W-1:0]          o_shift_count;

  modport slave (
    input  i_valid, i_overflow, i_sign, i_mantissa, i_exponent, i_ready,
    output o_ready, o_valid, o_sign, o_mantissa, o_exponent,
           o_zero, o_denorm, o_exp_overflow, o_shift_count
  );

  modport master (
    output i_valid, i_overflow, i_sign, i_mantissa, i_exponent, i_ready,
    input  o_ready, o_valid, o_sign, o_mantissa, o_exponent,
           o_zero, o_denorm, o_exp_overflow, o_shift_count
  );
endinterface

// File: rtl/mantissa_normalizer.sv
// Purpose: normalizes a raw add/sub mantissa so its leading one sits at bit SIZE_MANTISSA-1, adjusting the exponent.
// Latency: k+1 clock edges after capture for k left shifts (1 edge for overflow/zero/already-normalized cases).
// Backpressure: one operation in flight; o_ready only in IDLE, result held in DONE until i_ready.
// Ports: i_clk (rising edge), i_rst (async active-high), bus (mantissa_normalizer_if.slave):
//   i_valid/o_ready + i_overflow/i_sign/i_mantissa/i_exponent in,
//   o_valid/i_ready + o_sign/o_mantissa/o_exponent/o_zero/o_denorm/o_exp_overflow/o_shift_count out.
module mantissa_normalizer #(
  parameter int SIZE_MANTISSA = 28,
  parameter int SIZE_EXP      = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  mantissa_normalizer_if.slave   bus
);

  localparam int SC_W = $clog2(SIZE_MANTISSA) + 1;
  localparam logic [SIZE_EXP-1:0] EXP_MAX  = '1;
  localparam logic [SIZE_EXP-1:0] EXP_ONE  = SIZE_EXP'(1);
  localparam logic [SC_W-1:0]     SC_ONE   = SC_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // working registers double as the registered outputs
  logic                     sign_q,   sign_nxt;
  logic                     ovf_q,    ovf_nxt;
  logic [SIZE_MANTISSA-1:0] mant_q,   mant_nxt;
  logic [SIZE_EXP-1:0]      exp_q,    exp_nxt;
  logic [SC_W-1:0]          shift_q,  shift_nxt;
  logic                     zero_q,   zero_nxt;
  logic                     denorm_q, denorm_nxt;
  logic                     eovf_q,   eovf_nxt;

  // one extra bit so an exponent already at all-ones cannot wrap past the overflow test
  logic [SIZE_EXP:0] exp_inc;
  assign exp_inc = {1'b0, exp_q} + {{SIZE_EXP{1'b0}}, 1'b1};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sign_nxt   = sign_q;
    ovf_nxt    = ovf_q;
    mant_nxt   = mant_q;
    exp_nxt    = exp_q;
    shift_nxt  = shift_q;
    zero_nxt   = zero_q;
    denorm_nxt = denorm_q;
    eovf_nxt   = eovf_q;

    case (state)
      IDLE: begin
        if (bus.i_valid) begin
          sign_nxt   = bus.i_sign;
          ovf_nxt    = bus.i_overflow;
          mant_nxt   = bus.i_mantissa;
          exp_nxt    = bus.i_exponent;
          shift_nxt  = '0;
          zero_nxt   = 1'b0;
          denorm_nxt = 1'b0;
          eovf_nxt   = 1'b0;
          state_nxt  = NORM;
        end
      end

      NORM: begin
        if (ovf_q) begin
          // adder carried out: shift right by one, carry becomes the leading one,
          // the two dropped-out LSBs fold into a sticky bit
          state_nxt = DONE;
          if (exp_inc >= {1'b0, EXP_MAX}) begin
            eovf_nxt = 1'b1;
            exp_nxt  = EXP_MAX;
            mant_nxt = '0;
          end else begin
            mant_nxt = {1'b1, mant_q[SIZE_MANTISSA-1:2], mant_q[1] | mant_q[0]};
            exp_nxt  = exp_inc[SIZE_EXP-1:0];
          end
        end else if (mant_q == '0) begin
          // exact cancellation: canonical +0
          zero_nxt  = 1'b1;
          sign_nxt  = 1'b0;
          exp_nxt   = '0;
          mant_nxt  = '0;
          state_nxt = DONE;
        end else if (mant_q[SIZE_MANTISSA-1]) begin
          state_nxt = DONE;
        end else if (exp_q > EXP_ONE) begin
          mant_nxt  = {mant_q[SIZE_MANTISSA-2:0], 1'b0};
          exp_nxt   = exp_q - EXP_ONE;
          shift_nxt = shift_q + SC_ONE;
        end else begin
          // exponent floor reached before the leading one: subnormal result
          exp_nxt    = '0;
          denorm_nxt = 1'b1;
          state_nxt  = DONE;
        end
      end

      DONE: begin
        if (bus.i_ready) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      mant_q   <= '0;
      exp_q    <= '0;
      shift_q  <= '0;
      zero_q   <= 1'b0;
      denorm_q <= 1'b0;
      eovf_q   <= 1'b0;
    end else begin
      sign_q   <= sign_nxt;
      ovf_q    <= ovf_nxt;
      mant_q   <= mant_nxt;
      exp_q    <= exp_nxt;
      shift_q  <= shift_nxt;
      zero_q   <= zero_nxt;
      denorm_q <= denorm_nxt;
      eovf_q   <= eovf_nxt;
    end
  end

  assign bus.o_ready        = (state == IDLE);
  assign bus.o_valid        = (state == DONE);
  assign bus.o_sign         = sign_q;
  assign bus.o_mantissa     = mant_q;
  assign bus.o_exponent     = exp_q;
  assign bus.o_zero         = zero_q;
  assign bus.o_denorm       = denorm_q;
  assign bus.o_exp_overflow = eovf_q;
  assign bus.o_shift_count  = shift_q;

endmodule

// File: tb/tb_mantissa_normalizer.sv
// Purpose: directed table-driven bench for mantissa_normalizer plus reset/backpressure sequences.
// Latency: measures edges from capture to o_valid per vector.
// Backpressure: exercises held i_ready=0 in DONE and i_ready=1 outside DONE.
module tb_mantissa_normalizer;

  logic clk;
  logic rst;

  mantissa_normalizer_if #(.SIZE_MANTISSA(28), .SIZE_EXP(8)) bus ();

  mantissa_normalizer #(.SIZE_MANTISSA(28), .SIZE_EXP(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ovf;
    logic        sign;
    logic [27:0] mant;
    logic [7:0]  exp;
    int          edges;
    logic [27:0] r_mant;
    logic [7:0]  r_exp;
    logic        r_sign;
    logic        r_zero;
    logic        r_den;
    logic        r_eovf;
    logic [5:0]  r_sc;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(logic ovf, logic sign, logic [27:0] mant, logic [7:0] exp, int edges,
                              logic [27:0] r_mant, logic [7:0] r_exp, logic r_sign,
                              logic r_zero, logic r_den, logic r_eovf, logic [5:0] r_sc);
    vec_t v;
    v.ovf = ovf; v.sign = sign; v.mant = mant; v.exp = exp; v.edges = edges;
    v.r_mant = r_mant; v.r_exp = r_exp; v.r_sign = r_sign;
    v.r_zero = r_zero; v.r_den = r_den; v.r_eovf = r_eovf; v.r_sc = r_sc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_result(input string tag, input vec_t v);
    check({tag, " mant"},   64'(bus.o_mantissa),     64'(v.r_mant));
    check({tag, " exp"},    64'(bus.o_exponent),     64'(v.r_exp));
    check({tag, " sign"},   64'(bus.o_sign),         64'(v.r_sign));
    check({tag, " zero"},   64'(bus.o_zero),         64'(v.r_zero));
    check({tag, " denorm"}, 64'(bus.o_denorm),       64'(v.r_den));
    check({tag, " expovf"}, 64'(bus.o_exp_overflow), 64'(v.r_eovf));
    check({tag, " shift"},  64'(bus.o_shift_count),  64'(v.r_sc));
  endtask

  // Present one operation, count edges to o_valid, check the result.
  // Leaves the DUT in DONE with i_ready as given by rdy_during.
  task automatic start_and_wait(input string tag, input vec_t v, input logic rdy_during);
    int edges;
    @(negedge clk);
    bus.i_ready    = rdy_during;
    bus.i_valid    = 1'b1;
    bus.i_overflow = v.ovf;
    bus.i_sign     = v.sign;
    bus.i_mantissa = v.mant;
    bus.i_exponent = v.exp;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    edges = 0;
    while (!bus.o_valid && edges < 64) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, " latency"}, 64'(edges), 64'(v.edges));
    check_result(tag, v);
  endtask

  task automatic finish_handshake(input string tag);
    @(negedge clk);
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    check({tag, " idle valid"}, 64'(bus.o_valid), 64'd0);
    check({tag, " idle ready"}, 64'(bus.o_ready), 64'd1);
  endtask

  initial begin
    bit stable;
    bit saw_valid;
    vec_t hold_v;

    vecs[0]  = mk(1'b0, 1'b0, 28'h0800000, 8'd10,  5,  28'h8000000, 8'd6,   1'b0, 1'b0, 1'b0, 1'b0, 6'd4);
    vecs[1]  = mk(1'b1, 1'b0, 28'h0000003, 8'd20,  1,  28'h8000001, 8'd21,  1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    vecs[2]  = mk(1'b1, 1'b1, 28'h0000003, 8'd254, 1,  28'h0000000, 8'd255, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0);
    vecs[3]  = mk(1'b0, 1'b1, 28'h0000000, 8'd50,  1,  28'h0000000, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    vecs[4]  = mk(1'b0, 1'b0, 28'h0000001, 8'd3,   3,  28'h0000004, 8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 6'd2);
    vecs[5]  = mk(1'b0, 1'b1, 28'h8123456, 8'd100, 1,  28'h8123456, 8'd100, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    vecs[6]  = mk(1'b0, 1'b0, 28'h0400000, 8'd0,   1,  28'h0400000, 8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
    vecs[7]  = mk(1'b0, 1'b1, 28'h0000001, 8'd200, 28, 28'h8000000, 8'd173, 1'b1, 1'b0, 1'b0, 1'b0, 6'd27);
    vecs[8]  = mk(1'b1, 1'b0, 28'hFFFFFFF, 8'd0,   1,  28'hFFFFFFF, 8'd1,   1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    vecs[9]  = mk(1'b1, 1'b1, 28'h0000004, 8'd253, 1,  28'h8000002, 8'd254, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    vecs[10] = mk(1'b0, 1'b0, 28'h0000001, 8'd2,   2,  28'h0000002, 8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 6'd1);

    bus.i_valid    = 1'b0;
    bus.i_ready    = 1'b0;
    bus.i_overflow = 1'b0;
    bus.i_sign     = 1'b0;
    bus.i_mantissa = '0;
    bus.i_exponent = '0;

    // reset state
    rst = 1'b1;
    #12;
    check("rst valid",  64'(bus.o_valid),        64'd0);
    check("rst mant",   64'(bus.o_mantissa),     64'd0);
    check("rst exp",    64'(bus.o_exponent),     64'd0);
    check("rst flags",  64'({bus.o_sign, bus.o_zero, bus.o_denorm, bus.o_exp_overflow}), 64'd0);
    check("rst shift",  64'(bus.o_shift_count),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst ready",  64'(bus.o_ready),        64'd1);

    // table-driven vectors
    for (int i = 0; i < 11; i++) begin
      start_and_wait($sformatf("vec%0d", i), vecs[i], 1'b0);
      finish_handshake($sformatf("vec%0d", i));
    end

    // i_ready high outside DONE must not disturb the operation
    start_and_wait("rdy_early", vecs[4], 1'b1);
    @(posedge clk);
    #1;
    check("rdy_early back idle", 64'(bus.o_ready), 64'd1);

    // hold results in DONE for 10 cycles while a second request is offered
    hold_v = vecs[0];
    start_and_wait("hold", hold_v, 1'b0);
    stable = 1'b1;
    @(negedge clk);
    bus.i_valid    = 1'b1;
    bus.i_overflow = 1'b1;
    bus.i_mantissa = 28'h0000007;
    bus.i_exponent = 8'd77;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (!bus.o_valid || bus.o_ready || bus.o_mantissa !== hold_v.r_mant ||
          bus.o_exponent !== hold_v.r_exp || bus.o_shift_count !== hold_v.r_sc)
        stable = 1'b0;
    end
    check("hold stable", 64'(stable), 64'd1);
    @(negedge clk);
    bus.i_valid = 1'b0;
    finish_handshake("hold");
    saw_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) saw_valid = 1'b1;
    end
    check("hold second ignored", 64'(saw_valid), 64'd0);

    // asynchronous reset in the middle of NORM
    @(negedge clk);
    bus.i_valid    = 1'b1;
    bus.i_overflow = 1'b0;
    bus.i_sign     = 1'b1;
    bus.i_mantissa = 28'h0800000;
    bus.i_exponent = 8'd10;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst mant",  64'(bus.o_mantissa), 64'd0);
    check("arst exp",   64'(bus.o_exponent), 64'd0);
    check("arst valid", 64'(bus.o_valid),    64'd0);
    check("arst sign",  64'(bus.o_sign),     64'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) saw_valid = 1'b1;
    end
    check("arst no valid", 64'(saw_valid), 64'd0);
    start_and_wait("after_arst", vecs[0], 1'b0);
    finish_handshake("after_arst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
